// File: rtl/final_key_schedule_if.sv
// final_key_schedule_if
//   Handshake bundle between the key-expansion stage and whatever sits around
//   it. 64-bit keys are held in [63:0] vectors; vector bit 63 is the key's
//   bit 0 (MSB), so values compare directly as integers.
//   Signals:
//     start       request expansion (honoured only when the stage is idle)
//     master_key  key captured on the accepting edge
//     key_ready   consumer accepts final_key when key_valid && key_ready
//     busy        expansion rounds in progress
//     key_valid   final_key is valid and stable
//     final_key   expanded key
//   Modports: master = requester/consumer side, slave = the expansion stage.
interface final_key_schedule_if;
  logic        start;
  logic [63:0] master_key;
  logic        key_ready;
  logic        busy;
  logic        key_valid;
  logic [63:0] final_key;

  modport master (
    output start, master_key, key_ready,
    input  busy, key_valid, final_key
  );

  modport slave (
    input  start, master_key, key_ready,
    output busy, key_valid, final_key
  );
endinterface

// File: rtl/final_key_schedule.sv
// final_key_schedule
//   Derives the 64-bit final_key for the bit-level mixing stage from a
//   64-bit master key. Runs ROUNDS rotate/XOR rounds, one per clock, then
//   holds the result behind a valid/ready handshake.
//   Parameters:
//     ROUNDS  number of expansion rounds (1..255)
//     ROT     left-rotate amount per round (1..63)
//   Ports:
//     clk     rising-edge clock
//     rst_n   synchronous active-low reset
//     ks      final_key_schedule_if.slave (start/master_key/key_ready in,
//             busy/key_valid/final_key out)
//   Build option:
//     FINAL_KEY_SBOX_EN  when defined, every nibble of each round result is
//                        passed through a fixed 4-bit S-box; latency unchanged.
//   Round: k <= rotl64(k, ROT) ^ {8{r}} (then optional S-box), r = 1..ROUNDS.

`ifdef FINAL_KEY_SBOX_EN
// One nibble of the round substitution layer.
module final_key_sbox_nib (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);
  always_comb begin
    nib_o = 4'h0;
    case (nib_i)
      4'h0: nib_o = 4'hC;
      4'h1: nib_o = 4'h5;
      4'h2: nib_o = 4'h6;
      4'h3: nib_o = 4'hB;
      4'h4: nib_o = 4'h9;
      4'h5: nib_o = 4'h0;
      4'h6: nib_o = 4'hA;
      4'h7: nib_o = 4'hD;
      4'h8: nib_o = 4'h3;
      4'h9: nib_o = 4'hE;
      4'hA: nib_o = 4'hF;
      4'hB: nib_o = 4'h8;
      4'hC: nib_o = 4'h4;
      4'hD: nib_o = 4'h7;
      4'hE: nib_o = 4'h1;
      4'hF: nib_o = 4'h2;
      default: nib_o = 4'h0;
    endcase
  end
endmodule
`endif

module final_key_schedule #(
  parameter int ROUNDS = 8,
  parameter int ROT    = 13
) (
  input logic                 clk,
  input logic                 rst_n,
  final_key_schedule_if.slave ks
);

  localparam int         NIBS     = 16;
  localparam logic [7:0] ROUNDS_B = 8'(ROUNDS);

  if (ROUNDS < 1 || ROUNDS > 255) begin : g_bad_rounds
    $error("final_key_schedule: ROUNDS must be 1..255");
  end
  if (ROT < 1 || ROT > 63) begin : g_bad_rot
    $error("final_key_schedule: ROT must be 1..63");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    VALID = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] k_q, k_d;
  logic [7:0]  r_q, r_d;
  logic [63:0] fk_q, fk_d;

  // Round datapath: rotate, XOR the replicated round byte, optional S-box.
  logic [63:0]            rot_w;
  logic [NIBS-1:0][3:0]   mix_w;
  logic [NIBS-1:0][3:0]   rnd_w;

  assign rot_w = {k_q[63-ROT:0], k_q[63:64-ROT]};
  assign mix_w = rot_w ^ {8{r_q}};

`ifdef FINAL_KEY_SBOX_EN
  for (genvar n = 0; n < NIBS; n++) begin : g_sbox
    final_key_sbox_nib u_nib (
      .nib_i (mix_w[n]),
      .nib_o (rnd_w[n])
    );
  end
`else
  assign rnd_w = mix_w;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      r_q     <= '0;
      fk_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      r_q     <= r_d;
      fk_q    <= fk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    r_d     = r_q;
    fk_d    = fk_q;
    case (state_q)
      IDLE: begin
        if (ks.start) begin
          k_d     = ks.master_key;
          r_d     = 8'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        k_d = rnd_w;
        // r stops at ROUNDS (<= 255), so the 8-bit counter never wraps.
        if (r_q == ROUNDS_B) begin
          fk_d    = rnd_w;
          state_d = VALID;
        end else begin
          r_d = r_q + 8'd1;
        end
      end
      VALID: begin
        // final_key is left untouched on exit; it holds until the next result.
        if (ks.key_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; no input reaches them combinationally.
  assign ks.busy      = (state_q == RUN);
  assign ks.key_valid = (state_q == VALID);
  assign ks.final_key = fk_q;

endmodule

// File: tb/tb_final_key_schedule.sv
// Bench for final_key_schedule: three instances (ROUNDS = 1, 2, 8; ROT = 13)
// driven with directed and $urandom keys, checked against a loop-based model.
module tb_final_key_schedule;

  localparam int NI = 3;
  localparam int RN [NI] = '{1, 2, 8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [NI];
  logic        st    [NI];
  logic [63:0] mk    [NI];
  logic        rdy   [NI];
  logic        busy  [NI];
  logic        vld   [NI];
  logic [63:0] fk    [NI];

  final_key_schedule_if if0 ();
  final_key_schedule_if if1 ();
  final_key_schedule_if if2 ();

  assign if0.start = st[0]; assign if0.master_key = mk[0]; assign if0.key_ready = rdy[0];
  assign if1.start = st[1]; assign if1.master_key = mk[1]; assign if1.key_ready = rdy[1];
  assign if2.start = st[2]; assign if2.master_key = mk[2]; assign if2.key_ready = rdy[2];
  assign busy[0] = if0.busy; assign vld[0] = if0.key_valid; assign fk[0] = if0.final_key;
  assign busy[1] = if1.busy; assign vld[1] = if1.key_valid; assign fk[1] = if1.final_key;
  assign busy[2] = if2.busy; assign vld[2] = if2.key_valid; assign fk[2] = if2.final_key;

  final_key_schedule #(.ROUNDS(1), .ROT(13)) u_r1 (.clk(clk), .rst_n(rst_n[0]), .ks(if0));
  final_key_schedule #(.ROUNDS(2), .ROT(13)) u_r2 (.clk(clk), .rst_n(rst_n[1]), .ks(if1));
  final_key_schedule #(.ROUNDS(8), .ROT(13)) u_r8 (.clk(clk), .rst_n(rst_n[2]), .ks(if2));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: straight from the round rule, one loop iteration per round.
  function automatic logic [63:0] model(input logic [63:0] key, input int rounds);
    logic [63:0] k;
    logic [7:0]  rb;
    k = key;
    for (int r = 1; r <= rounds; r++) begin
      rb = 8'(r);
      k  = (k << 13) | (k >> 51);
      k  = k ^ {8{rb}};
`ifdef FINAL_KEY_SBOX_EN
      begin
        logic [3:0] sb [16];
        sb = '{4'hC,4'h5,4'h6,4'hB,4'h9,4'h0,4'hA,4'hD,4'h3,4'hE,4'hF,4'h8,4'h4,4'h7,4'h1,4'h2};
        for (int n = 0; n < 16; n++) k[4*n +: 4] = sb[k[4*n +: 4]];
      end
`endif
    end
    return k;
  endfunction

  // One full transaction on instance i. hold = cycles of key_ready=0 after
  // valid (0 means ready already high). poke pulses start in RUN and VALID.
  // The master_key bus is scrambled right after the accepting edge.
  task automatic xfer(input int i, input logic [63:0] key, input int hold,
                      input bit poke, output logic [63:0] got);
    logic [63:0] exp;
    int n;
    exp = model(key, RN[i]);
    rdy[i] = (hold == 0);
    @(negedge clk); st[i] = 1'b1; mk[i] = key;
    @(posedge clk); #1; st[i] = 1'b0; mk[i] = {$urandom, $urandom};
    chk($sformatf("busy_after_start[%0d]", i), busy[i], 1);
    n = 0;
    while (!vld[i] && n < 300) begin
      if (poke && n == 0) st[i] = 1'b1;
      @(posedge clk); #1;
      st[i] = 1'b0;
      n++;
    end
    chk($sformatf("latency[%0d]", i), n, RN[i]);
    chk($sformatf("final_key[%0d]", i), fk[i], exp);
    chk($sformatf("busy_in_valid[%0d]", i), busy[i], 0);
    got = fk[i];
    if (hold == 0) begin
      @(posedge clk); #1;
      chk($sformatf("valid_one_cycle[%0d]", i), vld[i], 0);
    end else begin
      for (int c = 0; c < hold; c++) begin
        if (poke && c == hold / 2) st[i] = 1'b1;
        @(posedge clk); #1;
        st[i] = 1'b0;
        chk($sformatf("bp_valid[%0d]", i), vld[i], 1);
        chk($sformatf("bp_key[%0d]", i), fk[i], exp);
      end
      rdy[i] = 1'b1;
      @(posedge clk); #1;
      rdy[i] = 1'b0;
      chk($sformatf("valid_drop[%0d]", i), vld[i], 0);
    end
    chk($sformatf("idle_not_busy[%0d]", i), busy[i], 0);
    chk($sformatf("key_kept[%0d]", i), fk[i], exp);
    rdy[i] = 1'b0;
  endtask

  logic [63:0] got;

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; st[i] = 1'b0; mk[i] = '0; rdy[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_busy[%0d]", i), busy[i], 0);
      chk($sformatf("rst_valid[%0d]", i), vld[i], 0);
      chk($sformatf("rst_key[%0d]", i), fk[i], 0);
      rst_n[i] = 1'b1;
    end

    // Directed values.
    xfer(0, 64'h0, 0, 1'b0, got);
    chk("r1_zero", got, 64'h0101010101010101);
    xfer(1, 64'h0, 0, 1'b0, got);
    chk("r2_zero", got, 64'h2222222222222222);
    xfer(0, 64'hFFFFFFFFFFFFFFFF, 0, 1'b0, got);
    chk("r1_ones", got, 64'hFEFEFEFEFEFEFEFE);

    // Backpressure with ignored start pulses in RUN and VALID.
    xfer(2, 64'h0123456789ABCDEF, 20, 1'b1, got);
    xfer(0, 64'hDEADBEEFCAFEF00D, 20, 1'b1, got);

    // Reset mid-RUN on the 8-round instance (final_key nonzero beforehand).
    @(negedge clk); st[2] = 1'b1; mk[2] = 64'hA5A5A5A5A5A5A5A5;
    @(posedge clk); #1; st[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n[2] = 1'b0;
    @(posedge clk); #1;
    chk("midrun_rst_busy", busy[2], 0);
    chk("midrun_rst_valid", vld[2], 0);
    chk("midrun_rst_key", fk[2], 0);
    rst_n[2] = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", busy[2], 0);
    xfer(2, 64'h0, 0, 1'b0, got);
    xfer(0, 64'h0, 0, 1'b0, got);
    chk("post_rst_r1", got, 64'h0101010101010101);

    // Randomized keys, instances and backpressure.
    for (int t = 0; t < 12; t++) begin
      xfer(int'($urandom_range(NI - 1)), {$urandom, $urandom},
           int'($urandom_range(3)), 1'($urandom_range(1)), got);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/final_key_schedule.md
# final_key_schedule

Sequential key-expansion stage that derives the 64-bit `final_key` consumed by the `bit_level_mixing` encode/decode datapath from a 64-bit master key. Runs a fixed number of rotate/XOR rounds, one per clock, and presents the result on a valid/ready handshake. Sits directly upstream of the mixing stage. The mixing stage samples `final_key` only while `key_valid` is high.

## Interface
- `ROUNDS`, 8: number of expansion rounds; legal range 1..255.
- `ROT`, 13: left-rotate amount per round; legal range 1..63.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start` in 1: request expansion; accepted only in IDLE.
- `master_key` in 64: bit 0 is MSB; captured on the accepting edge.
- `busy` out 1: high in RUN.
- `key_valid` out 1: high in VALID; `final_key` is stable while high.
- `key_ready` in 1: consumer accepts the key when `key_valid && key_ready`.
- `final_key` out 64: expanded key, bit 0 is MSB.

## Operation
- FSM states: IDLE, RUN, VALID.
- **IDLE, `start`=1**
  - `k` <= `master_key`; round counter `r` <= 1 (8-bit); go to RUN.
  - `start`=0: stay in IDLE.
- **RUN**
  - Each cycle: `k` <= rotl64(`k`, ROT) XOR RC(`r`), where RC(`r`) = byte `r` replicated 8 times (e.g. RC(2)=0x0202020202020202).
  - SBOX step applies per the Configuration section.
  - If `r`==ROUNDS: `final_key` <= round result and go to VALID. Otherwise `r` <= `r`+1.
- **VALID**
  - `key_valid`=1 and `final_key` is held.
  - On `key_ready`=1: go to IDLE; `key_valid` drops next cycle. `final_key` keeps its last value.
- `start` in RUN or VALID is ignored; it is not queued.
- `master_key` changes after the accepting edge have no effect.
- `r` never wraps: ROUNDS ≤ 255 and the counter is 8 bits.
- Reset, including mid-RUN or in VALID: FSM=IDLE; `k`, `r`, `final_key` = 0; `busy`=0; `key_valid`=0. Any in-flight expansion is discarded.

## Timing
- `start` sampled high in IDLE at edge E0.
  - `busy` is high from E0 through E0+ROUNDS.
  - `key_valid` and the new `final_key` are visible after edge E0+ROUNDS.
  - Latency from start to valid is ROUNDS cycles.
- `key_valid` stays high until the first edge where `key_ready`=1, with unlimited backpressure.
  - If `key_ready` is already high on the cycle `key_valid` rises, the handshake completes at the next edge, so `key_valid` is high for exactly 1 cycle.
- The earliest next `start` acceptance is the cycle after return to IDLE.
  - Back-to-back throughput is one key per ROUNDS+2 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `FINAL_KEY_SBOX_EN`
  - Defined: after the XOR in each round, every 4-bit nibble of the result passes through the fixed S-box {C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2} (index = nibble value). Latency is unchanged.
  - Undefined: no substitution; the round is rotate + XOR only.
- All test-plan values below assume the macro is undefined.

## Test plan
- **ROUNDS=1:** `master_key`=0, pulse `start`, `key_ready`=1.
  - Required: `key_valid` after 1 cycle with `final_key`=0x0101010101010101.
  - Required: `key_valid` high for exactly 1 cycle.
- **ROUNDS=2, ROT=13:** `master_key`=0.
  - Required: `final_key`=0x2222222222222222 after edge E0+2.
- **ROUNDS=1:** `master_key`=0xFFFFFFFFFFFFFFFF.
  - Required: `final_key`=0xFEFEFEFEFEFEFEFE.
- **Backpressure:** hold `key_ready`=0 for 20 cycles after valid, and pulse `start` during RUN and during VALID.
  - Required: `key_valid` stays high and `final_key` is unchanged throughout.
  - Required: both `start` pulses are ignored.
  - Then `key_ready`=1 for 1 cycle: IDLE the next cycle.
- **Reset mid-RUN:** ROUNDS=8, `rst_n`=0 at cycle 3 of RUN.
  - Required: `busy`=0, `key_valid`=0, `final_key`=0 after that edge.
  - Then a new `start` with `master_key`=0 and ROUNDS=1 yields 0x0101010101010101.
- **Input capture:** change `master_key` on the cycle after `start` is accepted.
  - Required: result matches the originally captured key.
